// File: rtl/maheredia_req_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : maheredia_req_conditioner                                     |
// | Purpose  : Two-channel button conditioner: 2-FF sync, counter debounce,  |
// |            rising-edge pulse per channel, plus same-cycle tie flag.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module maheredia_req_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_in,
    input  logic req1_raw_in,
    input  logic req2_raw_in,
    output logic req1_out,
    output logic req2_out,
    output logic req1_pulse_out,
    output logic req2_pulse_out,
    output logic tie_out
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] w_raw;
    logic       r_tie;

    assign w_raw = {req2_raw_in, req1_raw_in};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_stable;
        logic             r_pulse;
        logic [CNT_W-1:0] r_cnt;
        logic             w_accept;
        logic             w_rise;

        // A change is accepted on the edge where the Nth consecutive differing sample arrives
        assign w_accept = (r_sync2 != r_stable) && (r_cnt == c_cnt_max);
        assign w_rise   = w_accept && r_sync2;

        always_ff @(posedge clk) begin
            if (rst_in) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_pulse  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                r_pulse <= w_rise;
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_tie <= 1'b0;
        end else begin
            r_tie <= g_chan[0].w_rise && g_chan[1].w_rise;
        end
    end

    assign req1_out       = g_chan[0].r_stable;
    assign req2_out       = g_chan[1].r_stable;
    assign req1_pulse_out = g_chan[0].r_pulse;
    assign req2_pulse_out = g_chan[1].r_pulse;
    assign tie_out        = r_tie;

endmodule
`default_nettype wire
